// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port between pipeline writeback (WB)
// and a long-latency unit (LL, e.g. mult/div). LL results wait in a small
// FIFO. WB normally wins the port. A starvation counter forces one WB stall
// cycle so that an LL result cannot be bypassed forever. Decode gets busy
// flags for its two source registers so it can stall on pending LL results.
//
// Handshakes:
//   WB : a request (wb_valid with wb_addr != 0) is accepted in any cycle where
//        wb_stall=0. When wb_stall=1 the pipeline must hold the same request
//        on the next cycle. wb_valid with wb_addr == 0 is not a request.
//   LL : valid/ready. A result transfers at the clock edge when
//        ll_valid & ll_ready. ll_ready only depends on FIFO occupancy, never
//        on ll_valid. A transferred result with ll_addr == 0 is dropped.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   wb_valid/addr/data    writeback write request
//   wb_stall              WB request not accepted this cycle (comb.)
//   ll_valid/addr/data    long-latency result offer
//   ll_ready              LL FIFO not full
//   ll_count              LL FIFO occupancy
//   rs_addr, rt_addr      decode source registers
//   rs_busy, rt_busy      source has a pending LL write (comb.)
//   rf_we/waddr/wdata     registered register-file write port
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_addr,
    input  logic [31:0]                wb_data,
    output logic                       wb_stall,
    input  logic                       ll_valid,
    output logic                       ll_ready,
    input  logic [4:0]                 ll_addr,
    input  logic [31:0]                ll_data,
    output logic [$clog2(DEPTH+1)-1:0] ll_count,
    input  logic [4:0]                 rs_addr,
    input  logic [4:0]                 rt_addr,
    output logic                       rs_busy,
    output logic                       rt_busy,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // LL FIFO storage; ent_valid marks occupied slots so busy lookup is a
    // plain per-slot match without pointer arithmetic.
    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;
    logic             out_is_ll;   // output stage holds an LL-sourced write

    logic fifo_empty;
    logic fifo_full;
    logic wb_req;
    logic grant_wb;
    logic grant_ll;
    logic push;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        wb_req     = wb_valid && (wb_addr != 5'd0);
        // Stall lasts one cycle: the forced LL pop clears the counter.
        wb_stall   = (starve_cnt == STARVE_MAX) && !fifo_empty;
        grant_ll   = !fifo_empty && (wb_stall || !wb_req);
        grant_wb   = wb_req && !wb_stall;
        // No push-on-pop when full: ready depends on occupancy only.
        ll_ready   = !fifo_full;
        push       = ll_valid && ll_ready && (ll_addr != 5'd0);
        ll_count   = count;
    end

    // Busy: any occupied FIFO slot or an LL write sitting in the output stage.
    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                if ((rs_addr != 5'd0) && (ent_addr[i] == rs_addr)) rs_busy = 1'b1;
                if ((rt_addr != 5'd0) && (ent_addr[i] == rt_addr)) rt_busy = 1'b1;
            end
        end
        if (rf_we && out_is_ll) begin
            if ((rs_addr != 5'd0) && (rf_waddr == rs_addr)) rs_busy = 1'b1;
            if ((rt_addr != 5'd0) && (rf_waddr == rt_addr)) rt_busy = 1'b1;
        end
    end

    // FIFO payload; contents are only meaningful where ent_valid is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= ll_addr;
            ent_data[wr_ptr] <= ll_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ent_valid  <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 32'd0;
            out_is_ll  <= 1'b0;
        end else begin
            // Pop and push never touch the same slot: a pop needs a non-empty
            // FIFO and a push a non-full one, so rd_ptr != wr_ptr when both fire.
            if (grant_ll) begin
                rd_ptr            <= rd_ptr + PW'(1);
                ent_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr            <= wr_ptr + PW'(1);
                ent_valid[wr_ptr] <= 1'b1;
            end

            case ({push, grant_ll})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Counts cycles an eligible head lost the port to WB.
            if (grant_ll || fifo_empty) begin
                starve_cnt <= '0;
            end else if (grant_wb && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (grant_ll) begin
                rf_we     <= 1'b1;
                rf_waddr  <= ent_addr[rd_ptr];
                rf_wdata  <= ent_data[rd_ptr];
                out_is_ll <= 1'b1;
            end else if (grant_wb) begin
                rf_we     <= 1'b1;
                rf_waddr  <= wb_addr;
                rf_wdata  <= wb_data;
                out_is_ll <= 1'b0;
            end else begin
                // Address and data hold; only the enable drops.
                rf_we     <= 1'b0;
                out_is_ll <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed stimulus against rf_write_arbiter. A queue-based model of the
// arbiter tracks the pending LL results, the bypass count and the expected
// register-file write; a compare process checks every output against it on
// each falling edge. Directed sections add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int CW           = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          wb_stall;
    logic          ll_valid;
    logic          ll_ready;
    logic [4:0]    ll_addr;
    logic [31:0]   ll_data;
    logic [CW-1:0] ll_count;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic          rs_busy;
    logic          rt_busy;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;

    rf_write_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_stall (wb_stall),
        .ll_valid (ll_valid),
        .ll_ready (ll_ready),
        .ll_addr  (ll_addr),
        .ll_data  (ll_data),
        .ll_count (ll_count),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_busy  (rs_busy),
        .rt_busy  (rt_busy),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];        // pending LL results, head first
    int          m_bypass;     // cycles the eligible head lost to WB
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_from_ll;

    function automatic bit m_stall();
        return (m_bypass == STARVE_LIMIT) && (mq.size() != 0);
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == a) return 1'b1;
        return m_we && m_from_ll && (m_waddr == a);
    endfunction

    task automatic m_clear();
        mq.delete();
        m_bypass  = 0;
        m_we      = 1'b0;
        m_waddr   = 5'd0;
        m_wdata   = 32'd0;
        m_from_ll = 1'b0;
    endtask

    // Model advances on each rising edge using the inputs held across it.
    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_clear();
            end else begin
                bit   req, stall, had_head, room, take_ll, take_wb;
                ent_t head;
                req      = wb_valid && (wb_addr != 5'd0);
                stall    = m_stall();
                had_head = (mq.size() != 0);
                room     = (mq.size() < DEPTH);
                take_ll  = had_head && (stall || !req);
                take_wb  = req && !stall;
                if (take_ll) begin
                    head      = mq.pop_front();
                    m_we      = 1'b1;
                    m_waddr   = head.a;
                    m_wdata   = head.d;
                    m_from_ll = 1'b1;
                end else if (take_wb) begin
                    m_we      = 1'b1;
                    m_waddr   = wb_addr;
                    m_wdata   = wb_data;
                    m_from_ll = 1'b0;
                end else begin
                    m_we      = 1'b0;
                    m_from_ll = 1'b0;
                end
                if (take_ll || !had_head) m_bypass = 0;
                else if (take_wb && m_bypass < STARVE_LIMIT) m_bypass++;
                if (ll_valid && room && (ll_addr != 5'd0))
                    mq.push_back('{a: ll_addr, d: ll_data});
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset && cmp_en) begin
                chk("rf_we",    32'(rf_we),    32'(m_we));
                chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
                chk("rf_wdata", rf_wdata,      m_wdata);
                chk("wb_stall", 32'(wb_stall), 32'(m_stall()));
                chk("ll_ready", 32'(ll_ready), 32'(mq.size() < DEPTH));
                chk("ll_count", 32'(ll_count), 32'(mq.size()));
                chk("rs_busy",  32'(rs_busy),  32'(m_busy(rs_addr)));
                chk("rt_busy",  32'(rt_busy),  32'(m_busy(rt_addr)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        ll_valid = 1'b0;
        ll_addr  = 5'd0;
        ll_data  = 32'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle_inputs();
        while (ll_count != '0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(ll_count), 32'd0);
        step();
        step();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bit held;
        int n_push;

        idle_inputs();
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        reset   = 1'b0;
        #2;
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata,      32'd0);
        chk("rst_ll_count", 32'(ll_count), 32'd0);
        chk("rst_ll_ready", 32'(ll_ready), 32'd1);
        chk("rst_wb_stall", 32'(wb_stall), 32'd0);
        step();
        reset  = 1'b1;
        cmp_en = 1'b1;
        step();

        // WB write with empty FIFO: one-cycle latency.
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 32'h0000_1234;
        step();
        idle_inputs();
        #1;
        chk("wb_we",    32'(rf_we),    32'd1);
        chk("wb_waddr", 32'(rf_waddr), 32'd5);
        chk("wb_wdata", rf_wdata,      32'h0000_1234);
        step();
        chk("wb_we_drop",   32'(rf_we),    32'd0);
        chk("wb_addr_hold", 32'(rf_waddr), 32'd5);

        // Single LL push while idle: busy t+1..t+2, write visible at t+2.
        rs_addr  = 5'd9;
        ll_valid = 1'b1;
        ll_addr  = 5'd9;
        ll_data  = 32'hDEAD_BEEF;
        #1;
        chk("ll1_busy_t", 32'(rs_busy), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("ll1_busy_t1",  32'(rs_busy),  32'd1);
        chk("ll1_count_t1", 32'(ll_count), 32'd1);
        chk("ll1_we_t1",    32'(rf_we),    32'd0);
        step();
        chk("ll1_busy_t2",  32'(rs_busy),  32'd1);
        chk("ll1_we_t2",    32'(rf_we),    32'd1);
        chk("ll1_waddr_t2", 32'(rf_waddr), 32'd9);
        chk("ll1_wdata_t2", rf_wdata,      32'hDEAD_BEEF);
        chk("ll1_count_t2", 32'(ll_count), 32'd0);
        step();
        chk("ll1_busy_t3", 32'(rs_busy), 32'd0);
        chk("ll1_we_t3",   32'(rf_we),   32'd0);

        // WB every cycle, five LL results: FIFO fills, 5th waits for a pop.
        rs_addr = 5'd22;
        rt_addr = 5'd24;
        held    = 1'b0;
        n_push  = 0;
        for (int c = 0; c < 13; c++) begin
            if (!held) begin
                wb_addr = 5'(c + 1);
                wb_data = 32'hB000_0000 | 32'(c);
            end
            wb_valid = 1'b1;
            ll_valid = (n_push < 5);
            ll_addr  = 5'(20 + n_push);
            ll_data  = 32'hC000_0000 | 32'(n_push);
            #1;
            if (c == 4) begin
                chk("fill_count_c4", 32'(ll_count), 32'd4);
                chk("fill_ready_c4", 32'(ll_ready), 32'd0);
            end
            if (c == 9) begin
                chk("fill_stall_c9", 32'(wb_stall), 32'd1);
                chk("fill_ready_c9", 32'(ll_ready), 32'd0);
                chk("fill_rs_c9",    32'(rs_busy),  32'd1);
                chk("fill_rt_c9",    32'(rt_busy),  32'd0);
            end
            if (c == 10) begin
                chk("fill_ready_c10", 32'(ll_ready), 32'd1);
                chk("fill_count_c10", 32'(ll_count), 32'd3);
                chk("fill_we_c10",    32'(rf_we),    32'd1);
                chk("fill_waddr_c10", 32'(rf_waddr), 32'd20);
                chk("fill_stall_c10", 32'(wb_stall), 32'd0);
            end
            if (c == 11) begin
                chk("fill_count_c11", 32'(ll_count), 32'd4);
                chk("fill_rt_c11",    32'(rt_busy),  32'd1);
            end
            if (ll_valid && ll_ready) n_push++;
            held = wb_stall;
            step();
        end
        drain();

        // Starvation: one LL at t under constant WB -> stall only at t+9.
        rs_addr = 5'd7;
        rt_addr = 5'd10;
        held    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!held) begin
                wb_addr = 5'(k + 1);
                wb_data = 32'hA000_0000 | 32'(k);
            end
            wb_valid = 1'b1;
            ll_valid = (k == 0);
            ll_addr  = 5'd7;
            ll_data  = 32'h0000_7777;
            #1;
            if (k == 8) chk("starve_stall_t8", 32'(wb_stall), 32'd0);
            if (k == 9) chk("starve_stall_t9", 32'(wb_stall), 32'd1);
            if (k == 10) begin
                chk("starve_stall_t10", 32'(wb_stall), 32'd0);
                chk("starve_we_t10",    32'(rf_we),    32'd1);
                chk("starve_waddr_t10", 32'(rf_waddr), 32'd7);
                chk("starve_wdata_t10", rf_wdata,      32'h0000_7777);
                chk("starve_rs_t10",    32'(rs_busy),  32'd1);
            end
            if (k == 11) begin
                chk("starve_waddr_t11", 32'(rf_waddr), 32'd10);
                chk("starve_wdata_t11", rf_wdata,      32'hA000_0009);
                chk("starve_rt_t11",    32'(rt_busy),  32'd0);
            end
            held = wb_stall;
            step();
        end
        drain();

        // WB with address 0 leaves the slot to the pending LL head.
        rs_addr  = 5'd12;
        ll_valid = 1'b1;
        ll_addr  = 5'd12;
        ll_data  = 32'h0000_000C;
        step();
        idle_inputs();
        wb_valid = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'hFFFF_FFFF;
        #1;
        chk("wb0_stall", 32'(wb_stall), 32'd0);
        chk("wb0_count", 32'(ll_count), 32'd1);
        chk("wb0_busy",  32'(rs_busy),  32'd1);
        step();
        idle_inputs();
        #1;
        chk("wb0_ll_we",    32'(rf_we),    32'd1);
        chk("wb0_ll_waddr", 32'(rf_waddr), 32'd12);
        chk("wb0_ll_wdata", rf_wdata,      32'h0000_000C);
        chk("wb0_ll_count", 32'(ll_count), 32'd0);
        step();

        // LL push to address 0 is accepted and dropped.
        ll_valid = 1'b1;
        ll_addr  = 5'd0;
        ll_data  = 32'h5555_5555;
        #1;
        chk("ll0_ready", 32'(ll_ready), 32'd1);
        step();
        idle_inputs();
        #1;
        chk("ll0_count", 32'(ll_count), 32'd0);
        chk("ll0_we",    32'(rf_we),    32'd0);
        step();
        chk("ll0_we_next",   32'(rf_we),    32'd0);
        chk("ll0_addr_hold", 32'(rf_waddr), 32'd12);

        // Asynchronous reset in the middle of mixed traffic.
        rs_addr = 5'd17;
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1;
            wb_addr  = 5'd3;
            wb_data  = 32'h0000_0300 | 32'(k);
            ll_valid = 1'b1;
            ll_addr  = 5'(17 + k);
            ll_data  = 32'h1700_0000 | 32'(k);
            step();
        end
        #1;
        chk("pre_rst_count", 32'(ll_count), 32'd3);
        reset = 1'b0;
        #1;
        chk("mid_rst_we",    32'(rf_we),    32'd0);
        chk("mid_rst_count", 32'(ll_count), 32'd0);
        chk("mid_rst_ready", 32'(ll_ready), 32'd1);
        chk("mid_rst_stall", 32'(wb_stall), 32'd0);
        chk("mid_rst_busy",  32'(rs_busy),  32'd0);
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        chk("post_rst_we",    32'(rf_we),    32'd0);
        chk("post_rst_count", 32'(ll_count), 32'd0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time bound in case something stalls the directed sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
